// File: rtl/mem_pkg.sv
// +-----------------------------------------------------------------------+
// | Package  : mem_pkg                                                    |
// | Purpose  : Shared encodings for the load/store unit: req_op fields,   |
// |            FSM states and lane-select helpers.                        |
// | Options  : MEM_MISALIGN_TRAP_EN adds the ERR state and the            |
// |            misalignment check.                                        |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

   // req_op = {store, unsigned, size[1:0]}
   localparam int OP_STORE_BIT    = 3;
   localparam int OP_UNSIGNED_BIT = 2;

   localparam logic [1:0] SIZE_B   = 2'b00;
   localparam logic [1:0] SIZE_H   = 2'b01;
   localparam logic [1:0] SIZE_W   = 2'b10;
   localparam logic [1:0] SIZE_RSV = 2'b11;

   // Address bit that picks the upper halfword lane
   localparam int HALF_SEL_BIT = 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RMW_RD = 3'd2,
`ifdef MEM_MISALIGN_TRAP_EN
      ST_STORE  = 3'd3,
      ST_ERR    = 3'd4
`else
      ST_STORE  = 3'd3
`endif
   } state_t;

   // Reserved size 11 behaves exactly like a word access
   function automatic logic is_word(input logic [1:0] size);
      return (size == SIZE_W) || (size == SIZE_RSV);
   endfunction

`ifdef MEM_MISALIGN_TRAP_EN
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      return ((size == SIZE_H) && lo[0]) || (is_word(size) && (lo != 2'b00));
   endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// +-----------------------------------------------------------------------+
// | Module   : mem_lane_align                                             |
// | Purpose  : Combinational lane steering. Load path extracts and        |
// |            extends a byte/halfword; store path merges new data into   |
// |            the old RAM word for read-modify-write.                    |
// | Options  : none (alignment trapping is decided upstream)              |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [1:0]  lane,
   input  logic [31:0] old_word,
   input  logic [15:0] wdata_lo,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   assign byte_val = old_word[{lane, 3'b000} +: 8];
   assign half_val = lane[HALF_SEL_BIT] ? old_word[31:16] : old_word[15:0];

   // Select the addressed lane for loads and splice new data in for stores
   always_comb begin
      load_data  = old_word;
      merge_data = old_word;
      case (size)
         SIZE_B: begin
            load_data = {{24{~uns & byte_val[7]}}, byte_val};
            merge_data[{lane, 3'b000} +: 8] = wdata_lo[7:0];
         end
         SIZE_H: begin
            load_data = {{16{~uns & half_val[15]}}, half_val};
            if (lane[HALF_SEL_BIT]) merge_data[31:16] = wdata_lo;
            else                    merge_data[15:0]  = wdata_lo;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +-----------------------------------------------------------------------+
// | Module   : mem_access_unit                                            |
// | Purpose  : Load/store controller between execute stage and data RAM:  |
// |            one request at a time, sub-word loads with extension and   |
// |            read-modify-write sub-word stores.                         |
// | Options  : MEM_MISALIGN_TRAP_EN - misaligned half/word accesses       |
// |            complete with resp_err instead of touching the RAM.        |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int RAM_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              ram_we,
   output logic [31:0]       ram_addr,
   output logic [31:0]       ram_datain,
   input  logic [31:0]       ram_dataout
);

   // The RAM word index must fit inside the byte address
   if (RAM_AW + 2 > ADDR_W) begin : g_ram_aw_check
      $error("RAM_AW too large for ADDR_W");
   end

   state_t      state;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic [31:0] merge_q;
   logic [31:0] load_data;
   logic [31:0] merge_data;
   logic [31:0] addr_ext;

   assign addr_ext   = 32'(req_addr);
   assign req_ready  = (state == ST_IDLE);
   // Reset in STORE must suppress the write in that same cycle
   assign ram_we     = (state == ST_STORE) & ~rst;
   assign ram_datain = is_word(size_q) ? wdata_q : merge_q;

`ifndef MEM_MISALIGN_TRAP_EN
   assign resp_err = 1'b0;
`endif

   mem_lane_align u_align (
      .size       (size_q),
      .uns        (uns_q),
      .lane       (lane_q),
      .old_word   (ram_dataout),
      .wdata_lo   (wdata_q[15:0]),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // Request FSM with registered response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         merge_q    <= 32'h0;
         ram_addr   <= 32'h0;
         size_q     <= SIZE_B;
         uns_q      <= 1'b0;
         lane_q     <= 2'b00;
         wdata_q    <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
         resp_err   <= 1'b0;
`endif
      end else begin
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
         resp_err   <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  size_q   <= req_op[1:0];
                  uns_q    <= req_op[OP_UNSIGNED_BIT];
                  lane_q   <= req_addr[1:0];
                  wdata_q  <= req_wdata;
                  ram_addr <= {addr_ext[31:2], 2'b00};
`ifdef MEM_MISALIGN_TRAP_EN
                  if (misaligned(req_op[1:0], req_addr[1:0]))
                     state <= ST_ERR;
                  else
`endif
                  if (!req_op[OP_STORE_BIT])
                     state <= ST_LOAD;
                  else if (is_word(req_op[1:0]))
                     state <= ST_STORE;
                  else
                     state <= ST_RMW_RD;
               end
            end
            ST_LOAD: begin
               resp_rdata <= load_data;
               resp_valid <= 1'b1;
               state      <= ST_IDLE;
            end
            ST_RMW_RD: begin
               merge_q <= merge_data;
               state   <= ST_STORE;
            end
            ST_STORE: begin
               resp_valid <= 1'b1;
               state      <= ST_IDLE;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            ST_ERR: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b1;
               state      <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +-----------------------------------------------------------------------+
// | Module   : tb_mem_access_unit                                         |
// | Purpose  : Self-checking bench for mem_access_unit with a behavioural |
// |            RAM and an arithmetic reference model.                     |
// | Options  : MEM_MISALIGN_TRAP_EN changes expected misaligned behaviour |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;

   localparam int RAM_AW = 5;
   localparam int NWORDS = 1 << RAM_AW;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'h0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_datain;
   logic [31:0] ram_dataout;

   logic [31:0] ram [NWORDS];
   logic [31:0] ref_mem [NWORDS];
   logic        pl_en = 1'b0;
   int          pl_idx = 0;
   logic [31:0] pl_data = 32'h0;

   int ncmp = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32), .RAM_AW(RAM_AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_datain  (ram_datain),
      .ram_dataout (ram_dataout)
   );

   // Behavioural RAM: combinational read, write on posedge, bench preload port
   assign ram_dataout = ram[ram_addr[RAM_AW+1:2]];
   always @(posedge clk) begin
      if (ram_we)     ram[ram_addr[RAM_AW+1:2]] <= ram_datain;
      else if (pl_en) ram[pl_idx] <= pl_data;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic poke(input int i, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = i; pl_data = d;
      ref_mem[i] = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // Issue one request; latency counts edges after acceptance (0 = timeout)
   task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat, output int wes);
      int guard;
      @(negedge clk);
      req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; wes = 0; rd = 32'h0; er = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (ram_we) wes++;
         if (resp_valid) begin
            lat = c - 1; rd = resp_rdata; er = resp_err;
            break;
         end
      end
   endtask

   // Reference model: expected outcome of a request, updating ref_mem for stores
   task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output int wes);
      int          idx  = int'(addr[RAM_AW+1:2]);
      int          off  = int'(addr % 4);
      int          hoff = int'((addr / 2) % 2);
      int          size = int'(op[1:0]);
      logic [31:0] w    = ref_mem[idx];
      logic [31:0] v;
      logic [31:0] mask;
      logic        mis  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      if (size == 1 && (addr % 2) != 0) mis = 1'b1;
      if (size >= 2 && off != 0)        mis = 1'b1;
`endif
      rd = 32'h0; er = 1'b0; lat = 1; wes = 0;
      if (mis) begin
         er = 1'b1;
         return;
      end
      if (op[3] == 1'b0) begin
         if (size == 0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!op[2] && v >= 32'h80) v = v + 32'hFFFFFF00;
         end else if (size == 1) begin
            v = (w >> (16 * hoff)) & 32'hFFFF;
            if (!op[2] && v >= 32'h8000) v = v + 32'hFFFF0000;
         end else begin
            v = w;
         end
         rd = v;
      end else begin
         wes = 1;
         if (size >= 2) begin
            w = wd;
         end else if (size == 0) begin
            lat  = 2;
            mask = 32'hFF << (8 * off);
            w    = (w & ~mask) | ((wd & 32'hFF) << (8 * off));
         end else begin
            lat  = 2;
            mask = 32'hFFFF << (16 * hoff);
            w    = (w & ~mask) | ((wd & 32'hFFFF) << (16 * hoff));
         end
         ref_mem[idx] = w;
      end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_wes;
      int          ram_idx;
      logic [31:0] exp_ram;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          lat, mlat, wes, mwes, lowcnt, guard;
      logic [3:0]  op;
      logic [31:0] addr, wd;

      //            op     addr   wdata     rdata         lat wes idx word
      vecs[0] = '{4'b0000, 32'h15, 32'h0,    32'h0000007F, 1, 0, 5, 32'h80FF7F01};
      vecs[1] = '{4'b0000, 32'h17, 32'h0,    32'hFFFFFF80, 1, 0, 5, 32'h80FF7F01};
      vecs[2] = '{4'b0100, 32'h17, 32'h0,    32'h00000080, 1, 0, 5, 32'h80FF7F01};
      vecs[3] = '{4'b0001, 32'h16, 32'h0,    32'hFFFF80FF, 1, 0, 5, 32'h80FF7F01};
      vecs[4] = '{4'b0101, 32'h14, 32'h0,    32'h00007F01, 1, 0, 5, 32'h80FF7F01};
      vecs[5] = '{4'b0010, 32'h14, 32'h0,    32'h80FF7F01, 1, 0, 5, 32'h80FF7F01};
      vecs[6] = '{4'b1000, 32'h09, 32'hAB,   32'h00000000, 2, 1, 2, 32'h1122AB44};
      vecs[7] = '{4'b1001, 32'h0A, 32'hBEEF, 32'h00000000, 2, 1, 2, 32'hBEEFAB44};

      // Preload under reset so the DUT cannot write
      for (int i = 0; i < NWORDS; i++) poke(i, 32'h0);
      poke(5, 32'h80FF7F01);
      poke(2, 32'h11223344);

      @(negedge clk);
      chk("reset_req_ready",  32'(req_ready),  32'h1);
      chk("reset_resp_valid", 32'(resp_valid), 32'h0);
      chk("reset_resp_err",   32'(resp_err),   32'h0);
      chk("reset_resp_rdata", resp_rdata,      32'h0);
      chk("reset_ram_addr",   ram_addr,        32'h0);
      chk("reset_ram_we",     32'(ram_we),     32'h0);
      rst = 1'b0;

      // Directed table
      for (int i = 0; i < 8; i++) begin
         do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, er, lat, wes);
         model(vecs[i].op, vecs[i].addr, vecs[i].wdata, mrd, mer, mlat, mwes);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_err", i),   32'(er), 32'h0);
         chk($sformatf("vec%0d_lat", i),   32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("vec%0d_we", i),    32'(wes), 32'(vecs[i].exp_wes));
         chk($sformatf("vec%0d_ram", i),   ram[vecs[i].ram_idx], vecs[i].exp_ram);
         chk($sformatf("vec%0d_model", i), vecs[i].exp_rdata, mrd);
      end

      // Misaligned word store to 0x02
      do_req(4'b1010, 32'h02, 32'hCAFEF00D, rd, er, lat, wes);
      model(4'b1010, 32'h02, 32'hCAFEF00D, mrd, mer, mlat, mwes);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("mis_err", 32'(er),  32'h1);
      chk("mis_we",  32'(wes), 32'h0);
      chk("mis_ram", ram[0],   32'h0);
`else
      chk("mis_err", 32'(er),  32'h0);
      chk("mis_we",  32'(wes), 32'h1);
      chk("mis_ram", ram[0],   32'hCAFEF00D);
`endif
      chk("mis_lat", 32'(lat), 32'h1);

      // Back-to-back sw then lw
      @(negedge clk);
      req_op = 4'b1010; req_addr = 32'h0; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
      @(posedge clk);
      #1 req_op = 4'b0010;
      lowcnt = 0; guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 10) begin
         lowcnt++; guard++;
         @(negedge clk);
      end
      chk("b2b_ready_low", 32'(lowcnt), 32'h1);
      chk("b2b_sw_resp",   32'(resp_valid), 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_lw_not_yet", 32'(resp_valid), 32'h0);
      @(negedge clk);
      chk("b2b_lw_resp",  32'(resp_valid), 32'h1);
      chk("b2b_lw_rdata", resp_rdata, 32'hDEADBEEF);
      ref_mem[0] = 32'hDEADBEEF;

      // Reset asserted during the STORE cycle of a halfword store
      @(negedge clk);
      req_op = 4'b1001; req_addr = 32'h0A; req_wdata = 32'h1234; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_store_we_before", 32'(ram_we), 32'h1);
      rst = 1'b1;
      #1 chk("rst_store_we_abort", 32'(ram_we), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_store_ready", 32'(req_ready),  32'h1);
      chk("rst_store_valid", 32'(resp_valid), 32'h0);
      chk("rst_store_ram",   ram[2], 32'hBEEFAB44);

      // Randomized requests against the reference model
      for (int n = 0; n < 150; n++) begin
         op   = 4'($urandom);
         addr = $urandom;
         wd   = $urandom;
         model(op, addr, wd, mrd, mer, mlat, mwes);
         do_req(op, addr, wd, rd, er, lat, wes);
         chk("rand_rdata", rd, mrd);
         chk("rand_err",   32'(er),  32'(mer));
         chk("rand_lat",   32'(lat), 32'(mlat));
         chk("rand_we",    32'(wes), 32'(mwes));
         chk("rand_ram",   ram[addr[RAM_AW+1:2]], ref_mem[addr[RAM_AW+1:2]]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

`default_nettype wire
